sar_out_capture: RTL and testbench
==================================

SAR_OUT_CAPTURE -- requirements
Module: sar_out_capture

Interface
REQ-001 Parameters: SYNC_STAGES, default 2, synchronizer depth for asynchronous inputs; FIFO_DEPTH, fixed at 2, output buffer entries.
REQ-002 CLK  input  1  sole clock; all state changes on rising CLK.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 CKS  input  1  asynchronous sample clock; high means conversion phase, low means sample/clear phase.
REQ-005 RDY  input  1  asynchronous comparator-ready strobe; one rising edge per bit decision.
REQ-006 COMP_P  input  1  asynchronous comparator decision, stable while RDY is high; 1 means bit = 1.
REQ-007 FINAL  input  1  asynchronous end-of-conversion flag from the cyclic-flag stage.
REQ-008 DREADY  input  1  downstream accepts DOUT this cycle.
REQ-009 CLR  input  1  single-cycle pulse that clears the sticky flags.
REQ-010 DOUT  output  9  head-of-buffer conversion code, MSB first captured.
REQ-011 DVALID  output  1  buffer not empty.
REQ-012 OVF  output  1  sticky: a completed code was dropped because the buffer was full.
REQ-013 ERR  output  1  sticky: conversion aborted or ended with other than 9 bits.
REQ-014 CONV_CNT  output  8  count of codes pushed, wraps 255 to 0.

Function
REQ-015 CKS, RDY, COMP_P and FINAL shall each pass through a SYNC_STAGES flop chain; COMP_P shall share RDY's chain depth so both are aligned.
REQ-016 Edge detectors on synchronized signals shall give one-cycle events: cks_rise, cks_fall, rdy_rise, final_rise.
REQ-017 FSM states shall be IDLE and CONV.
REQ-018 IDLE to CONV on cks_rise: bit index := 0 and shift register := 0.
REQ-019 In CONV, each rdy_rise with index < 9 shall write synchronized COMP_P into code bit (8 - index) and increment index.
REQ-020 rdy_rise with index = 9 shall be ignored.
REQ-021 In CONV, final_rise with index = 9 shall push the code and return to IDLE.
REQ-022 In CONV, final_rise with index < 9 shall discard the code, set ERR and return to IDLE.
REQ-023 In CONV, cks_fall before final_rise shall discard the code, set ERR and return to IDLE.
REQ-024 If cks_fall and final_rise occur in the same cycle, final_rise shall take priority.
REQ-025 In IDLE, rdy_rise and final_rise shall be ignored.
REQ-026 Latency: DVALID shall rise exactly 1 CLK after the cycle where final_rise is detected, when the buffer was empty.
REQ-027 The buffer shall be a 2-entry FIFO; DOUT shows the oldest entry.
REQ-028 A pop shall occur when DVALID and DREADY are both high.
REQ-029 When the buffer is full, a push in the same cycle as a pop shall succeed.
REQ-030 When the buffer is full, a push without a pop shall drop the new code, set OVF and leave CONV_CNT unchanged.
REQ-031 DOUT shall hold its value while DVALID is high and DREADY is low.
REQ-032 CONV_CNT shall increment only on a successful push.
REQ-033 CLR shall clear OVF and ERR; a set event in the same cycle as CLR shall win.

Reset
REQ-034 While RST is high at a CLK edge, the block shall enter IDLE.
REQ-035 On reset, index, code, FIFO pointers and CONV_CNT shall be 0; DOUT = 0, DVALID = 0, OVF = 0 and ERR = 0.
REQ-036 On reset, synchronizer flops shall be 0.
REQ-037 Reset mid-conversion shall discard partial data without setting ERR.
REQ-038 The first cks_rise after RST is released shall start a fresh conversion.

Verification
REQ-039 Nominal: CKS high, 9 RDY pulses with COMP_P = 1,0,1,1,0,0,1,0,1, then FINAL -> DOUT = 9'b101100101, DVALID 1 cycle after sync FINAL, CONV_CNT = 1.
REQ-040 Short conversion: 5 RDY pulses, then FINAL -> no push, ERR = 1, DVALID = 0; CLR pulse -> ERR = 0.
REQ-041 Abort: CKS falls after 4 RDY pulses -> ERR = 1 and FSM in IDLE; the next full conversion pushes correctly.
REQ-042 Backpressure: DREADY = 0 with 3 codes A, B, C -> FIFO holds A, B; OVF = 1; CONV_CNT = 2; then DREADY = 1 -> A then B out, DVALID = 0.
REQ-043 Full buffer with simultaneous push and pop: buffer = {A,B}, push C while popping A -> {B,C}, OVF unchanged, CONV_CNT increments.
REQ-044 Reset mid-conversion: RST after 6 RDY pulses -> all outputs at reset values, ERR = 0, and a subsequent conversion yields the correct code.

Source files
------------

// File: rtl/sar_out_capture.sv
// Captures a 9-bit SAR conversion from asynchronous comparator strobes and
// buffers completed codes in a small FIFO with sticky overflow/error flags.
module sar_out_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CKS,
  input  logic       RDY,
  input  logic       COMP_P,
  input  logic       FINAL,
  input  logic       DREADY,
  input  logic       CLR,
  output logic [8:0] DOUT,
  output logic       DVALID,
  output logic       OVF,
  output logic       ERR,
  output logic [7:0] CONV_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic {IDLE, CONV} state_t;

  // COMP_P rides in the same chain as RDY so the decision is aligned with its strobe.
  logic [3:0] async_in;
  logic [3:0] sync_out;
  assign async_in = {FINAL, COMP_P, RDY, CKS};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [3:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK) begin
          if (RST) stage_reg <= '0;
          else     stage_reg <= async_in;
        end
      end else begin : g_next
        always_ff @(posedge CLK) begin
          if (RST) stage_reg <= '0;
          else     stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;

  logic cks_s, rdy_s, comp_s, final_s;
  assign cks_s   = sync_out[0];
  assign rdy_s   = sync_out[1];
  assign comp_s  = sync_out[2];
  assign final_s = sync_out[3];

  logic [2:0] prev_reg;
  always_ff @(posedge CLK) begin
    if (RST) prev_reg <= '0;
    else     prev_reg <= {final_s, rdy_s, cks_s};
  end

  logic cks_rise, cks_fall, rdy_rise, final_rise;
  assign cks_rise   = cks_s & ~prev_reg[0];
  assign cks_fall   = ~cks_s & prev_reg[0];
  assign rdy_rise   = rdy_s & ~prev_reg[1];
  assign final_rise = final_s & ~prev_reg[2];

  state_t     state_reg;
  logic [3:0] idx_reg;
  logic [8:0] code_reg;
  logic       err_reg;
  logic       conv_done, conv_fail;

  // FINAL wins over a coincident CKS fall.
  always_comb begin
    conv_done = 1'b0;
    conv_fail = 1'b0;
    if (state_reg == CONV) begin
      if (final_rise) begin
        conv_done = (idx_reg == LAST_IDX);
        conv_fail = (idx_reg != LAST_IDX);
      end else if (cks_fall) begin
        conv_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      code_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cks_rise) begin
            state_reg <= CONV;
            idx_reg   <= '0;
            code_reg  <= '0;
          end
        end
        CONV: begin
          if (final_rise || cks_fall) begin
            state_reg <= IDLE;
          end else if (rdy_rise && idx_reg < LAST_IDX) begin
            code_reg[4'd8 - idx_reg] <= comp_s;
            idx_reg <= idx_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (conv_fail)  err_reg <= 1'b1;
      else if (CLR)   err_reg <= 1'b0;
    end
  end

  logic [8:0]     mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0] count_reg;
  logic [7:0]     cnt_reg;
  logic           ovf_reg;
  logic           full, pop, push_ok, drop;

  assign full    = (count_reg == FULL_CNT);
  assign pop     = DVALID & DREADY;
  assign push_ok = conv_done & (~full | pop);
  assign drop    = conv_done & full & ~pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= code_reg;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        cnt_reg    <= cnt_reg + 8'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop)     ovf_reg <= 1'b1;
      else if (CLR) ovf_reg <= 1'b0;
    end
  end

  assign DOUT     = mem_reg[rd_ptr_reg];
  assign DVALID   = (count_reg != '0);
  assign OVF      = ovf_reg;
  assign ERR      = err_reg;
  assign CONV_CNT = cnt_reg;

endmodule

// File: tb/tb_sar_out_capture.sv
// Scoreboard bench for sar_out_capture: expected codes are queued when a
// conversion is driven and compared as the FIFO hands them out.
module tb_sar_out_capture;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, cks, rdy, comp, fin, dready, clr;
  logic [8:0] dout;
  logic       dvalid, ovf, err;
  logic [7:0] conv_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int exp_cnt   = 0;
  logic [8:0] exp_q [$];

  sar_out_capture #(.SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .CKS(cks), .RDY(rdy), .COMP_P(comp), .FINAL(fin),
    .DREADY(dready), .CLR(clr), .DOUT(dout), .DVALID(dvalid), .OVF(ovf),
    .ERR(err), .CONV_CNT(conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each output transfer is compared against the oldest queued code.
  always @(negedge clk) begin
    if (!rst && dvalid && dready) begin
      check_val("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_val("dout_pop", dout, exp_q.pop_front());
    end
  end

  task automatic conv(input logic [8:0] code, input int nbits, input bit do_final,
                      input bit push_exp, input bit meas_lat, input bit pop_at_push);
    int lat;
    cks = 1'b1;
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      comp = (i < 9) ? code[8-i] : ~code[0];
      cyc(1);
      rdy = 1'b1;
      cyc(3);
      rdy = 1'b0;
      cyc(2);
    end
    if (!do_final) begin
      cks = 1'b0;
      cyc(6);
      return;
    end
    if (push_exp) begin
      exp_q.push_back(code);
      exp_cnt++;
    end
    fin = 1'b1;
    if (pop_at_push) begin
      cyc(SYNC_STAGES);
      dready = 1'b1;
      cyc(1);
      dready = 1'b0;
    end
    if (meas_lat) begin
      lat = 0;
      while (lat < 20 && !dvalid) begin
        cyc(1);
        lat++;
      end
      check_val("dvalid_latency", lat, SYNC_STAGES + 1);
    end
    cyc(5);
    cks = 1'b0;
    fin = 1'b0;
    cyc(6);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cks = 1'b0; rdy = 1'b0; comp = 1'b0; fin = 1'b0;
    dready = 1'b0; clr = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check_val("rst_dvalid", dvalid, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_err", err, 0);
    check_val("rst_cnt", conv_cnt, 0);

    // Nominal conversion, held at the output by backpressure
    conv(9'b101100101, 9, 1, 1, 1, 0);
    check_val("nom_dout_hold", dout, 9'b101100101);
    check_val("nom_cnt", conv_cnt, exp_cnt);
    check_val("nom_err", err, 0);
    dready = 1'b1;
    cyc(4);
    check_val("nom_drained", dvalid, 0);

    // Short conversion
    conv(9'h1FF, 5, 1, 0, 0, 0);
    check_val("short_err", err, 1);
    check_val("short_dvalid", dvalid, 0);
    check_val("short_cnt", conv_cnt, exp_cnt);
    pulse_clr();
    check_val("short_clr_err", err, 0);

    // Abort by CKS fall, then a full conversion with one extra ignored strobe
    conv(9'h0F0, 4, 0, 0, 0, 0);
    check_val("abort_err", err, 1);
    check_val("abort_dvalid", dvalid, 0);
    pulse_clr();
    conv(9'h0A7, 10, 1, 1, 0, 0);
    cyc(3);
    check_val("after_abort_cnt", conv_cnt, exp_cnt);
    check_val("after_abort_err", err, 0);
    check_val("after_abort_q", exp_q.size(), 0);

    // Backpressure: third code dropped
    dready = 1'b0;
    conv(9'h155, 9, 1, 1, 0, 0);
    conv(9'h0AA, 9, 1, 1, 0, 0);
    conv(9'h1E1, 9, 1, 0, 0, 0);
    check_val("bp_ovf", ovf, 1);
    check_val("bp_cnt", conv_cnt, exp_cnt);
    check_val("bp_head", dout, 9'h155);
    check_val("bp_dvalid", dvalid, 1);
    dready = 1'b1;
    cyc(5);
    check_val("bp_drained", dvalid, 0);
    check_val("bp_q", exp_q.size(), 0);
    pulse_clr();
    check_val("bp_clr_ovf", ovf, 0);

    // Full buffer: push coincides with a pop
    dready = 1'b0;
    conv(9'h033, 9, 1, 1, 0, 0);
    conv(9'h1CC, 9, 1, 1, 0, 0);
    conv(9'h0E7, 9, 1, 1, 0, 1);
    check_val("sim_ovf", ovf, 0);
    check_val("sim_cnt", conv_cnt, exp_cnt);
    check_val("sim_head", dout, 9'h1CC);
    dready = 1'b1;
    cyc(5);
    check_val("sim_drained", dvalid, 0);
    check_val("sim_q", exp_q.size(), 0);

    // Reset in the middle of a conversion
    dready = 1'b0;
    cks = 1'b1;
    cyc(4);
    for (int i = 0; i < 6; i++) begin
      comp = 1'b1;
      cyc(1);
      rdy = 1'b1;
      cyc(3);
      rdy = 1'b0;
      cyc(2);
    end
    rst = 1'b1;
    cks = 1'b0;
    cyc(2);
    rst = 1'b0;
    exp_cnt = 0;
    cyc(1);
    check_val("mid_rst_dvalid", dvalid, 0);
    check_val("mid_rst_dout", dout, 0);
    check_val("mid_rst_err", err, 0);
    check_val("mid_rst_ovf", ovf, 0);
    check_val("mid_rst_cnt", conv_cnt, 0);
    conv(9'h1C3, 9, 1, 1, 1, 0);
    check_val("post_rst_dout", dout, 9'h1C3);
    check_val("post_rst_cnt", conv_cnt, exp_cnt);
    dready = 1'b1;
    cyc(4);
    check_val("post_rst_q", exp_q.size(), 0);
    check_val("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
